// File: rtl/klotski_pkg.sv
// Shared types for the klotski step sequencer: FSM states, step-program entry
// layout and the default 4x4 solving program.
package klotski_pkg;

  localparam int MAX_STEP  = 64;
  localparam int DEF_NSTEP = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Fields are sized for boards up to 16x16; the sequencer uses the low CW bits.
  typedef struct packed {
    logic [7:0] number;
    logic [7:0] target;
    logic       flag_next;
    logic       skip_en;
    logic [7:0] c0;
    logic [7:0] v0;
    logic [7:0] c1;
    logic [7:0] v1;
    logic [6:0] skip_to;
  } step_t;

  typedef step_t [0:MAX_STEP-1] prog_t;

  function automatic prog_t build_default_prog();
    prog_t p;
    p = '0;
    for (int i = 0; i < DEF_NSTEP; i++) begin
      p[i].number    = 8'((i % 15) + 1);
      p[i].target    = 8'(i % 16);
      p[i].flag_next = 1'(i % 2);
    end
    p[8].number  = 8'd5;
    p[8].target  = 8'd4;
    // Once tiles 3 and 4 sit home after step 2, steps 3..7 are redundant.
    p[2].skip_en = 1'b1;
    p[2].c0      = 8'd2;
    p[2].v0      = 8'd3;
    p[2].c1      = 8'd3;
    p[2].v1      = 8'd4;
    p[2].skip_to = 7'd8;
    return p;
  endfunction

  localparam prog_t DEFAULT_PROG = build_default_prog();

endpackage

// File: rtl/klotski_step_rom.sv
// Combinational step-program lookup; entries at or beyond NSTEP read as zero.
module klotski_step_rom
  import klotski_pkg::*;
#(
  parameter int NSTEP = 25
) (
  input  logic [5:0] i_idx,
  output step_t      o_entry
);

  always_comb begin
    o_entry = '0;
    if (int'(i_idx) < NSTEP) begin
      o_entry = DEFAULT_PROG[i_idx];
    end
  end

endmodule

// File: rtl/klotski_step_sequencer.sv
// Walks the step program, handing one move at a time to an external worker,
// latching its board/mask result and applying per-step skip rules.
module klotski_step_sequencer
  import klotski_pkg::*;
#(
  parameter int N     = 4,
  parameter int CW    = $clog2(N*N),
  parameter int NSTEP = 25,
  parameter int TMO_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [N*N*CW-1:0] i_klotski,
  output logic              o_wk_start,
  output logic              o_wk_abort,
  output logic [CW-1:0]     o_wk_number,
  output logic [CW-1:0]     o_wk_target,
  output logic              o_wk_flag,
  output logic [N*N*CW-1:0] o_wk_klotski,
  output logic [N*N-1:0]    o_wk_mask,
  input  logic              i_wk_done,
  input  logic [N*N*CW-1:0] i_wk_klotski,
  input  logic [N*N-1:0]    i_wk_mask,
  output logic              o_busy,
  output logic [5:0]        o_step,
  output logic              o_finished,
  output logic              o_error
);

  localparam int NC = N*N;
  localparam int BW = NC*CW;
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q;
  logic [BW-1:0]    board_q;
  logic [NC-1:0]    mask_q;
  logic [5:0]       step_q;
  logic [TMO_W-1:0] tmo_q;
  logic             wk_start_q;
  logic             wk_abort_q;
  logic [CW-1:0]    wk_number_q;
  logic [CW-1:0]    wk_target_q;
  logic             wk_flag_q;
  logic             finished_q;
  logic             error_q;

  step_t      cur_entry;
  step_t      nxt_entry;
  logic       skip_hit;
  logic [6:0] step_d;
  logic       flag_d;
  logic [5:0] nxt_idx;
  logic       unused_bits;

  // Two lookups: one judges the finished step, one prepares the next issue.
  klotski_step_rom #(.NSTEP(NSTEP)) u_rom_cur (
    .i_idx   (step_q),
    .o_entry (cur_entry)
  );

  klotski_step_rom #(.NSTEP(NSTEP)) u_rom_nxt (
    .i_idx   (nxt_idx),
    .o_entry (nxt_entry)
  );

  function automatic logic [CW-1:0] cell_at(input logic [BW-1:0] b, input logic [7:0] idx);
    logic [BW-1:0] sh;
    sh = b >> (32'(idx) * CW);
    return sh[CW-1:0];
  endfunction

  always_comb begin
    skip_hit = cur_entry.skip_en
            && (cell_at(board_q, cur_entry.c0) == cur_entry.v0[CW-1:0])
            && (cell_at(board_q, cur_entry.c1) == cur_entry.v1[CW-1:0]);
    step_d   = skip_hit ? cur_entry.skip_to : 7'(step_q) + 7'd1;
    flag_d   = skip_hit | cur_entry.flag_next;
    nxt_idx  = (state_q == ST_CHECK) ? step_d[5:0] : 6'd0;
  end

  assign unused_bits = ^{cur_entry, nxt_entry};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      board_q     <= '0;
      mask_q      <= '0;
      step_q      <= '0;
      tmo_q       <= '0;
      wk_start_q  <= 1'b0;
      wk_abort_q  <= 1'b0;
      wk_number_q <= '0;
      wk_target_q <= '0;
      wk_flag_q   <= 1'b0;
      finished_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wk_start_q <= 1'b0;
      wk_abort_q <= 1'b0;
      finished_q <= 1'b0;
      if (i_abort && state_q != ST_IDLE) begin
        // Abort beats a same-cycle worker result; only a live worker is told.
        state_q    <= ST_IDLE;
        wk_abort_q <= (state_q == ST_WAIT);
        tmo_q      <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_ERR: begin
            if (i_start) begin
              error_q <= 1'b0;
              state_q <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            board_q     <= i_klotski;
            mask_q      <= '0;
            step_q      <= '0;
            tmo_q       <= '0;
            wk_start_q  <= 1'b1;
            wk_number_q <= nxt_entry.number[CW-1:0];
            wk_target_q <= nxt_entry.target[CW-1:0];
            wk_flag_q   <= 1'b0;
            state_q     <= ST_ISSUE;
          end
          ST_ISSUE: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (i_wk_done) begin
              board_q <= i_wk_klotski;
              mask_q  <= i_wk_mask;
              tmo_q   <= '0;
              state_q <= ST_CHECK;
            end else if (tmo_q == TMO_LAST) begin
              tmo_q      <= tmo_q + TMO_W'(1);
              error_q    <= 1'b1;
              wk_abort_q <= 1'b1;
              state_q    <= ST_ERR;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          ST_CHECK: begin
            if (skip_hit) begin
              mask_q <= mask_q | (NC'(1) << cur_entry.c0) | (NC'(1) << cur_entry.c1);
            end
            step_q <= step_d[5:0];
            if (step_d >= 7'(NSTEP)) begin
              finished_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              wk_start_q  <= 1'b1;
              wk_number_q <= nxt_entry.number[CW-1:0];
              wk_target_q <= nxt_entry.target[CW-1:0];
              wk_flag_q   <= flag_d;
              state_q     <= ST_ISSUE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_wk_start   = wk_start_q;
  assign o_wk_abort   = wk_abort_q;
  assign o_wk_number  = wk_number_q;
  assign o_wk_target  = wk_target_q;
  assign o_wk_flag    = wk_flag_q;
  assign o_wk_klotski = board_q;
  assign o_wk_mask    = mask_q;
  assign o_step       = step_q;
  assign o_finished   = finished_q;
  assign o_error      = error_q;
  assign o_busy       = (state_q == ST_LOAD) || (state_q == ST_ISSUE) ||
                        (state_q == ST_WAIT) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_klotski_step_sequencer.sv
// Directed bench: a 4x4 sequencer with a 15-cycle worker timeout and a 5x5
// three-step sequencer, driven by hand-sequenced worker responses.
module tb_klotski_step_sequencer;

  localparam logic [63:0] BOARD_A = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] BOARD_B = 64'h1111_2222_3333_4444;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort_r;
  logic [63:0] klotski;
  logic        wk_start;
  logic        wk_abort;
  logic [3:0]  wk_number;
  logic [3:0]  wk_target;
  logic        wk_flag;
  logic [63:0] wk_klotski_o;
  logic [15:0] wk_mask_o;
  logic        wk_done;
  logic [63:0] wk_klotski_i;
  logic [15:0] wk_mask_i;
  logic        busy;
  logic [5:0]  step;
  logic        finished;
  logic        error;

  logic         s5_start;
  logic         s5_abort;
  logic [124:0] s5_klotski;
  logic         s5_wk_start;
  logic         s5_wk_abort;
  logic [4:0]   s5_wk_number;
  logic [4:0]   s5_wk_target;
  logic         s5_wk_flag;
  logic [124:0] s5_wk_klotski_o;
  logic [24:0]  s5_wk_mask_o;
  logic         s5_wk_done;
  logic [124:0] s5_wk_klotski_i;
  logic [24:0]  s5_wk_mask_i;
  logic         s5_busy;
  logic [5:0]   s5_step;
  logic         s5_finished;
  logic         s5_error;

  int n_cmp = 0;
  int n_bad = 0;

  klotski_step_sequencer #(.N(4), .NSTEP(25), .TMO_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort_r),
    .i_klotski    (klotski),
    .o_wk_start   (wk_start),
    .o_wk_abort   (wk_abort),
    .o_wk_number  (wk_number),
    .o_wk_target  (wk_target),
    .o_wk_flag    (wk_flag),
    .o_wk_klotski (wk_klotski_o),
    .o_wk_mask    (wk_mask_o),
    .i_wk_done    (wk_done),
    .i_wk_klotski (wk_klotski_i),
    .i_wk_mask    (wk_mask_i),
    .o_busy       (busy),
    .o_step       (step),
    .o_finished   (finished),
    .o_error      (error)
  );

  klotski_step_sequencer #(.N(5), .NSTEP(3), .TMO_W(4)) dut5 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (s5_start),
    .i_abort      (s5_abort),
    .i_klotski    (s5_klotski),
    .o_wk_start   (s5_wk_start),
    .o_wk_abort   (s5_wk_abort),
    .o_wk_number  (s5_wk_number),
    .o_wk_target  (s5_wk_target),
    .o_wk_flag    (s5_wk_flag),
    .o_wk_klotski (s5_wk_klotski_o),
    .o_wk_mask    (s5_wk_mask_o),
    .i_wk_done    (s5_wk_done),
    .i_wk_klotski (s5_wk_klotski_i),
    .i_wk_mask    (s5_wk_mask_i),
    .o_busy       (s5_busy),
    .o_step       (s5_step),
    .o_finished   (s5_finished),
    .o_error      (s5_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wk_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic answer(input int lat, input logic [63:0] b, input logic [15:0] m);
    repeat (lat) @(negedge clk);
    wk_done      = 1'b1;
    wk_klotski_i = b;
    wk_mask_i    = m;
    @(negedge clk);
    wk_done = 1'b0;
  endtask

  task automatic kick(input logic [63:0] b);
    klotski = b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, wk_start, wk_abort, finished, error, wk_flag} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, want 000000", {busy, wk_start, wk_abort, finished, error, wk_flag});
    end
    n_cmp++;
    if ({step, wk_number, wk_target} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_step_move: got %h, want 0", {step, wk_number, wk_target});
    end
    n_cmp++;
    if ({wk_klotski_o, wk_mask_o} !== 80'h0) begin
      n_bad++;
      $display("FAIL reset_board_mask: got %h, want 0", {wk_klotski_o, wk_mask_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset: done");
  endtask

  task automatic test_full_run();
    bit ok;
    int fin_cnt;
    int extra;
    logic [3:0] exp_num;
    logic [3:0] exp_tgt;
    logic exp_flag;
    kick(BOARD_A);
    for (int k = 0; k < 25; k++) begin
      wait_start(20, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL full_start%0d: no start pulse within 20 cycles, required one", k);
        return;
      end
      exp_num  = (k == 8) ? 4'd5 : 4'((k % 15) + 1);
      exp_tgt  = (k == 8) ? 4'd4 : 4'(k % 16);
      exp_flag = (k == 0) ? 1'b0 : 1'((k - 1) % 2);
      n_cmp++;
      if ({step, wk_number, wk_target, wk_flag} !== {6'(k), exp_num, exp_tgt, exp_flag}) begin
        n_bad++;
        $display("FAIL full_issue%0d: got step/num/tgt/flag %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d",
                 k, step, wk_number, wk_target, wk_flag, k, exp_num, exp_tgt, exp_flag);
      end
      answer(5, BOARD_B, 16'h0001);
    end
    fin_cnt = 0;
    extra   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (finished === 1'b1) fin_cnt++;
      if (wk_start === 1'b1) extra++;
    end
    n_cmp++;
    if (fin_cnt != 1 || extra != 0) begin
      n_bad++;
      $display("FAIL full_finish: got %0d finished / %0d extra starts, want 1 / 0", fin_cnt, extra);
    end
    n_cmp++;
    if ({busy, wk_mask_o, wk_klotski_o} !== {1'b0, 16'h0001, BOARD_B}) begin
      n_bad++;
      $display("FAIL full_final: got busy %b mask %h board %h, want 0 0001 %h", busy, wk_mask_o, wk_klotski_o, BOARD_B);
    end
    $display("test_full_run: done");
  endtask

  task automatic test_skip();
    bit ok;
    kick(BOARD_B);
    for (int k = 0; k < 3; k++) begin
      wait_start(20, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL skip_start%0d: no start pulse, required one", k);
        return;
      end
      answer(3, (k == 2) ? BOARD_A : BOARD_B, 16'h0000);
    end
    wait_start(20, ok);
    n_cmp++;
    if (!ok || {step, wk_number, wk_target, wk_flag} !== {6'd8, 4'd5, 4'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL skip_issue: got ok %b step/num/tgt/flag %0d/%0d/%0d/%0d, want 1 8/5/4/1",
               ok, step, wk_number, wk_target, wk_flag);
    end
    n_cmp++;
    if ({wk_mask_o, wk_klotski_o} !== {16'h000C, BOARD_A}) begin
      n_bad++;
      $display("FAIL skip_mask: got mask %h board %h, want 000c %h", wk_mask_o, wk_klotski_o, BOARD_A);
    end
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
    n_cmp++;
    if ({busy, wk_abort} !== 2'b00) begin
      n_bad++;
      $display("FAIL skip_issue_abort: got busy/wk_abort %b, want 00", {busy, wk_abort});
    end
    $display("test_skip: done");
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    int aborts;
    kick(BOARD_A);
    wait_start(20, ok);
    cnt    = 0;
    aborts = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (wk_abort === 1'b1) aborts++;
      if (error === 1'b1) break;
    end
    n_cmp++;
    if (!ok || cnt != 16) begin
      n_bad++;
      $display("FAIL tmo_latency: got ok %b, error after %0d cycles, want 1 and 16", ok, cnt);
    end
    n_cmp++;
    if (wk_abort !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_abort_pulse: got %b, want 1", wk_abort);
    end
    repeat (3) begin
      @(negedge clk);
      if (wk_abort === 1'b1) aborts++;
    end
    n_cmp++;
    if (aborts != 1 || {error, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_err_hold: got aborts %0d error/busy %b, want 1 and 10", aborts, {error, busy});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({error, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL tmo_restart: got error/busy %b, want 01", {error, busy});
    end
    wait_start(5, ok);
    n_cmp++;
    if (!ok || step !== 6'd0) begin
      n_bad++;
      $display("FAIL tmo_restart_issue: got ok %b step %0d, want 1 and 0", ok, step);
    end
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
    $display("test_timeout: done");
  endtask

  task automatic test_abort_done();
    bit ok;
    int fin;
    kick(BOARD_B);
    for (int k = 0; k < 3; k++) begin
      wait_start(20, ok);
      if (k == 1) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      answer(3, BOARD_B, 16'h0000);
    end
    wait_start(20, ok);
    n_cmp++;
    if (!ok || step !== 6'd3) begin
      n_bad++;
      $display("FAIL abort_step3: got ok %b step %0d, want 1 and 3", ok, step);
    end
    repeat (2) @(negedge clk);
    abort_r      = 1'b1;
    wk_done      = 1'b1;
    wk_klotski_i = BOARD_A;
    wk_mask_i    = 16'hFFFF;
    @(negedge clk);
    abort_r = 1'b0;
    wk_done = 1'b0;
    n_cmp++;
    if ({wk_abort, busy, finished} !== 3'b100) begin
      n_bad++;
      $display("FAIL abort_same_cycle: got wk_abort/busy/finished %b, want 100", {wk_abort, busy, finished});
    end
    n_cmp++;
    if ({wk_klotski_o, wk_mask_o} !== {BOARD_B, 16'h0000}) begin
      n_bad++;
      $display("FAIL abort_board_kept: got %h/%h, want %h/0000", wk_klotski_o, wk_mask_o, BOARD_B);
    end
    wk_done = 1'b1;
    @(negedge clk);
    wk_done = 1'b0;
    fin = 0;
    repeat (3) begin
      @(negedge clk);
      if (finished === 1'b1 || wk_abort === 1'b1) fin++;
    end
    n_cmp++;
    if (fin != 0 || wk_klotski_o !== BOARD_B) begin
      n_bad++;
      $display("FAIL abort_idle_done: got %0d pulses board %h, want 0 and %h", fin, wk_klotski_o, BOARD_B);
    end
    $display("test_abort_done: done");
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int ab;
    kick(BOARD_A);
    wait_start(20, ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok || {busy, wk_start, wk_abort, finished, error, step, wk_number, wk_target} !== 19'h0) begin
      n_bad++;
      $display("FAIL rst_wait_ctrl: got ok %b outputs %h, want 1 and 0", ok,
               {busy, wk_start, wk_abort, finished, error, step, wk_number, wk_target});
    end
    n_cmp++;
    if ({wk_klotski_o, wk_mask_o} !== 80'h0) begin
      n_bad++;
      $display("FAIL rst_wait_board: got %h, want 0", {wk_klotski_o, wk_mask_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ab = 0;
    repeat (4) begin
      @(negedge clk);
      if (wk_abort === 1'b1 || busy === 1'b1) ab++;
    end
    n_cmp++;
    if (ab != 0) begin
      n_bad++;
      $display("FAIL rst_wait_after: got %0d abort/busy cycles, want 0", ab);
    end
    $display("test_reset_mid_wait: done");
  endtask

  task automatic test_n5();
    bit ok;
    int fin_cnt;
    int first_fin;
    int extra;
    s5_klotski = {25{5'd7}};
    s5_start   = 1'b1;
    @(negedge clk);
    s5_start   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (s5_wk_start === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      n_cmp++;
      if (!ok || {s5_step, s5_wk_number, s5_wk_target} !== {6'(k), 5'(k + 1), 5'(k)}) begin
        n_bad++;
        $display("FAIL n5_issue%0d: got ok %b step/num/tgt %0d/%0d/%0d, want 1 %0d/%0d/%0d",
                 k, ok, s5_step, s5_wk_number, s5_wk_target, k, k + 1, k);
      end
      repeat (4) @(negedge clk);
      s5_wk_done      = 1'b1;
      s5_wk_klotski_i = '0;
      s5_wk_mask_i    = 25'h1;
      @(negedge clk);
      s5_wk_done = 1'b0;
    end
    fin_cnt   = 0;
    first_fin = -1;
    extra     = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s5_finished === 1'b1) begin
        fin_cnt++;
        if (first_fin < 0) first_fin = i;
      end
      if (s5_wk_start === 1'b1) extra++;
    end
    n_cmp++;
    if (fin_cnt != 1 || first_fin != 0 || extra != 0) begin
      n_bad++;
      $display("FAIL n5_finish: got %0d pulses at %0d, %0d extra starts, want 1 at 0, 0", fin_cnt, first_fin, extra);
    end
    n_cmp++;
    if ({s5_busy, s5_wk_mask_o} !== {1'b0, 25'h1}) begin
      n_bad++;
      $display("FAIL n5_final: got busy %b mask %h, want 0 0000001", s5_busy, s5_wk_mask_o);
    end
    $display("test_n5: done");
  endtask

  initial begin
    rst_n           = 1'b1;
    start           = 1'b0;
    abort_r         = 1'b0;
    klotski         = '0;
    wk_done         = 1'b0;
    wk_klotski_i    = '0;
    wk_mask_i       = '0;
    s5_start        = 1'b0;
    s5_abort        = 1'b0;
    s5_klotski      = '0;
    s5_wk_done      = 1'b0;
    s5_wk_klotski_i = '0;
    s5_wk_mask_i    = '0;
    test_reset();
    test_full_run();
    test_skip();
    test_timeout();
    test_abort_done();
    test_reset_mid_wait();
    test_n5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
